mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-ported unified instruction/data memory between the multi-cycle CPU datapath (port 0) and a debug/loader port (port 1) used to inspect or preload memory from the board switches. Each port runs a simple req/ack handshake. The arbiter serializes accesses, registers every memory-side control signal and returns read data with a fixed latency. It sits between the requesters and the synchronous-read memory macro.

## Interface
- `ADDR_W`, default 9: word-address width; the memory is 512 words deep.
- `DATA_W`, default 32: data width.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `p0_req`, `p1_req`  in  1  request; held high with that port's `addr`/`we`/`wdata` stable until the port's ack.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  ADDR_W  word address.
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data for that port; held until that port's next read completes.
- `mem_en`  out  1  memory enable (registered).
- `mem_we`  out  1  memory write enable (registered).
- `mem_addr`  out  ADDR_W  memory address (registered).
- `mem_wdata`  out  DATA_W  memory write data (registered).
- `mem_rdata`  in  DATA_W  memory read data; valid one cycle after the `mem_en` cycle.
- `busy`  out  1  high in every state except IDLE.
- `grant`  out  1  index of the port owning the current transaction; 0 when idle after reset.

## Operation
- FSM states: IDLE, ACCESS, RESP, DONE.
- IDLE, no request pending: remain in IDLE.
- IDLE, any `req` high: arbitrate between the ports, latch `grant`, and capture the winner's addr/we/wdata into the `mem_*` registers. Next state is ACCESS.
- ACCESS: `mem_en`=1; `mem_we` = captured `we`. Next state is RESP.
- RESP: `mem_en`=`mem_we`=0. On a read, capture `mem_rdata` into the granted port's `rdata` register. On a write, leave `rdata` unchanged. Next state is DONE.
- DONE: assert the granted port's `ack` for this cycle only. Next state is IDLE.
- A requester drops `req` on the cycle after its ack, or keeps it high to issue a new request; IDLE samples `req` as a new request either way.
- Arbitration is fixed priority, port 0 wins, unless the round-robin option is compiled in (see Configuration).
- Requests arriving during ACCESS, RESP or DONE are not sampled; they wait for IDLE.
- The arbiter never drives both `ack` outputs high in the same cycle.
- `mem_we` is never high outside ACCESS.
- Address and data pass through unchanged. There is no wrap or width conversion; the top-level word address is the byte address bits [ADDR_W+1:2].

## Timing
- Latency: `req` first seen high in cycle N (IDLE) gives `mem_en` in N+1, capture in N+2 and `ack` in N+3. Reads and writes have the same latency.
- Throughput: at most one transaction per 4 cycles.
- `p*_rdata` is valid in the ack cycle and stays stable until that port's next read capture.
- Reset value of all outputs is 0: `ack`, `rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `grant`.
- Reset also forces the FSM to IDLE and the round-robin pointer `last` to 1.
- Reset mid-transaction: the transaction is aborted with no ack. Any write already issued in ACCESS has completed in memory; nothing is retried.
- `req` dropped before ack is a protocol violation. The transaction still completes and the ack is still pulsed.

## Configuration
- Macro `MEM_ARB_RR_EN`.
- When defined: round-robin arbitration.
  - On a simultaneous request, grant the port ≠ `last`; update `last` to the granted port on every grant.
  - A lone requester is always granted.
- When undefined: fixed priority, port 0 always wins on a simultaneous request.
  - The `last` register and its logic are omitted.
  - Port 1 can starve while the CPU requests continuously.

## Test plan
- Reset, then single read: preload mem[0x10]=0xDEADBEEF; raise `p0_req` (we=0, addr=0x10) in cycle 0.
  - Required: `mem_en`=1 with `mem_addr`=0x10 in cycle 1.
  - Required: `p0_ack`=1 and `p0_rdata`=0xDEADBEEF in cycle 3; `busy` low in cycle 4.
- Write then read back: `p1_req` write addr=0x1FF data=0x12345678.
  - Required: `mem_we`=1 only in the ACCESS cycle; `p1_ack` in cycle 3.
  - Then a p1 read of 0x1FF returns 0x12345678 and `p0_rdata` is unchanged.
- Simultaneous requests, both held continuously for 4 transactions.
  - Without the macro: grants 0,0,0,0.
  - With `MEM_ARB_RR_EN`: grants 0,1,0,1.
- Request during busy: `p1_req` rises in the ACCESS cycle of a p0 transaction.
  - Required: p1 is granted in the IDLE cycle after `p0_ack`, and its `ack` arrives 4 cycles after `p0_ack`.
- Reset mid-operation: assert `rst` in the RESP cycle.
  - Required: next cycle all outputs are 0, no `ack` is ever pulsed, and the FSM returns to IDLE.
- Protocol checks throughout: `p0_ack` & `p1_ack` never both high; `ack` is always exactly one cycle wide.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes CPU (port 0) and debug/loader (port 1) accesses onto one
// synchronous-read memory. Define MEM_ARB_RR_EN for round-robin instead of port-0 priority.
module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p0_ack_o,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                txn_we_q, txn_we_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                busy_q, busy_d;
    logic                win_s;
`ifdef MEM_ARB_RR_EN
    logic                last_q, last_d;
`endif

    // Choose the port that wins if IDLE starts a transaction this cycle.
    always_comb begin
        win_s = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (p0_req_i && p1_req_i) begin
            win_s = ~last_q;
        end else begin
            win_s = p1_req_i;
        end
`else
        if (p0_req_i) begin
            win_s = 1'b0;
        end else begin
            win_s = p1_req_i;
        end
`endif
    end

    // Next-state and next-output logic; memory strobes are prepared one state early.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        txn_we_d    = txn_we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (p0_req_i || p1_req_i) begin
                    state_d     = ACCESS;
                    grant_d     = win_s;
                    txn_we_d    = win_s ? p1_we_i : p0_we_i;
                    mem_en_d    = 1'b1;
                    mem_we_d    = win_s ? p1_we_i : p0_we_i;
                    mem_addr_d  = win_s ? p1_addr_i : p0_addr_i;
                    mem_wdata_d = win_s ? p1_wdata_i : p0_wdata_i;
`ifdef MEM_ARB_RR_EN
                    last_d      = win_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // Memory output is valid now, one cycle after the enable cycle.
                if (!txn_we_q) begin
                    if (grant_q) begin
                        rdata1_d = mem_rdata_i;
                    end else begin
                        rdata0_d = mem_rdata_i;
                    end
                end else begin
                    rdata0_d = rdata0_q;
                end
                if (grant_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            txn_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            rdata0_q    <= {DATA_W{1'b0}};
            rdata1_q    <= {DATA_W{1'b0}};
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            txn_we_q    <= txn_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign p0_ack_o    = ack0_q;
    assign p1_ack_o    = ack1_q;
    assign p0_rdata_o  = rdata0_q;
    assign p1_rdata_o  = rdata1_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign grant_o     = grant_q;

endmodule
